// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches ROM instructions and issues each one to the controller over the start/waiting handshake
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [15:0]       imem_rdata_i,
    output logic [15:0]       instr_o,
    output logic              start_o,
    input  logic              waiting_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [15:0]       issued_count_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {IDLE, FETCH, LATCH, ISSUE, ACK, EXEC, ADVANCE, DONE, ERROR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d, issued_q, issued_d;
    logic              start_q, start_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [TW-1:0]     to_q, to_d;
    logic              to_hit;
    assign to_hit         = to_q == TW'(TIMEOUT - 1);
    assign imem_addr_o    = pc_q;
    assign instr_o        = instr_q;
    assign start_o        = start_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign issued_count_o = issued_q;
    // Next state and next registered outputs; start is scheduled one cycle ahead so the pulse lands inside ISSUE
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        issued_d = issued_q;
        start_d  = 1'b0;
        done_d   = done_q;
        error_d  = error_q;
        to_d     = to_q;
        case (state_q)
            IDLE, DONE, ERROR: if (run_i) begin
                state_d  = FETCH;
                pc_d     = '0;
                done_d   = 1'b0;
                error_d  = 1'b0;
                issued_d = '0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                instr_d = imem_rdata_i;
                if (imem_rdata_i[15:13] == 3'b111) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ISSUE;
                    start_d = waiting_i;
                    to_d    = '0;
                end
            end
            ISSUE: if (start_q) begin
                state_d = ACK;
                to_d    = '0;
            end else if (to_hit) begin
                state_d = ERROR;
                error_d = 1'b1;
            end else begin
                start_d = waiting_i;
                to_d    = to_q + TW'(1);
            end
            ACK: if (!waiting_i) begin
                state_d = EXEC;
                to_d    = '0;
            end else if (to_hit) begin
                state_d = ERROR;
                error_d = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
            EXEC: if (waiting_i) begin
                state_d = ADVANCE;
            end else if (to_hit) begin
                state_d = ERROR;
                error_d = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
            ADVANCE: begin
                issued_d = (&issued_q) ? issued_q : issued_q + 16'd1;
                if (pc_q == last_addr_i || &pc_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                pc_d     = '0;
                instr_d  = '0;
                issued_d = '0;
                done_d   = 1'b0;
                error_d  = 1'b0;
                to_d     = '0;
            end
        endcase
        busy_d = !(state_d inside {IDLE, DONE, ERROR});
    end
    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            issued_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            issued_q <= issued_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            to_q     <= to_d;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of instr_sequencer against a ROM and a simple controller model
module tb_instr_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, w = 1'b1, stuck = 1'b0;
    logic [7:0]  last = 8'd2, addr;
    logic [15:0] rdata = '0, instr, cnt, cur = '0;
    logic        start, busy, done, error, hs = 1'b0, prev_start = 1'b0;
    logic [15:0] rom [256];
    logic [15:0] seen [$];
    int          mode = 0, cd = 0, unstable = 0, double_start = 0;
    logic        run2 = 1'b0, w2 = 1'b1, start2, busy2, done2, error2, nz2 = 1'b0;
    logic [1:0]  addr2;
    logic [15:0] rdata2 = '0, instr2, cnt2;
    logic [15:0] rom2 [4];
    logic [15:0] seen2 [$];
    int          cd2 = 0, wrap2 = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run), .last_addr_i(last), .imem_addr_o(addr),
        .imem_rdata_i(rdata), .instr_o(instr), .start_o(start), .waiting_i(w), .busy_o(busy),
        .done_o(done), .error_o(error), .issued_count_o(cnt)
    );

    instr_sequencer #(.ADDR_W(2), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .run_i(run2), .last_addr_i(2'd3), .imem_addr_o(addr2),
        .imem_rdata_i(rdata2), .instr_o(instr2), .start_o(start2), .waiting_i(w2), .busy_o(busy2),
        .done_o(done2), .error_o(error2), .issued_count_o(cnt2)
    );

    // ROM and controller model: mode 0 normal, 1 waiting held low, 2 never completes after start
    always @(posedge clk) begin
        rdata <= rom[addr];
        if (mode == 1) w <= 1'b0;
        else if (start) begin
            w <= 1'b0;
            cd <= 2;
            stuck <= (mode == 2);
        end else if (cd != 0) cd <= cd - 1;
        else if (!(stuck && mode == 2)) w <= 1'b1;
    end

    // ROM and normal controller for the narrow-address instance
    always @(posedge clk) begin
        rdata2 <= rom2[addr2];
        if (start2) begin
            w2 <= 1'b0;
            cd2 <= 2;
        end else if (cd2 != 0) cd2 <= cd2 - 1;
        else w2 <= 1'b1;
    end

    // Record issued instructions, detect multi-cycle start and instr changes during a handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            hs = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (start) begin
                seen.push_back(instr);
                cur = instr;
                hs = 1'b1;
                if (prev_start) double_start++;
            end else if (hs && w) hs = 1'b0;
            if (hs && instr !== cur) unstable++;
            prev_start = start;
        end
    end

    // Record issues of the narrow instance and detect an address wrap while busy
    always @(negedge clk) begin
        if (start2) seen2.push_back(instr2);
        if (!busy2) nz2 = 1'b0;
        else if (addr2 != 2'd0) nz2 = 1'b1;
        else if (nz2) wrap2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_end(input int max);
        int i = 0;
        while (!(done || error) && i < max) begin
            @(negedge clk);
            i++;
        end
        if (i == max) begin
            checks++;
            errors++;
            $error("FAIL wait_end: observed no done/error within %0d cycles", max);
        end
    endtask

    task automatic wait_start(input int max);
        int i = 0;
        while (!start && i < max) begin
            @(negedge clk);
            i++;
        end
        if (i == max) begin
            checks++;
            errors++;
            $error("FAIL wait_start: observed no start within %0d cycles", max);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h2000 | 16'(i);
        rom[0] = 16'h2011;
        rom[1] = 16'h2822;
        rom[2] = 16'h3033;
        rom2[0] = 16'h2101;
        rom2[1] = 16'h2202;
        rom2[2] = 16'h2303;
        rom2[3] = 16'h2404;
        repeat (3) @(negedge clk);
        check("rst_instr", instr, 16'h0);
        check("rst_addr", addr, 8'h0);
        check("rst_flags", {start, busy, done, error}, 4'b0000);
        check("rst_count", cnt, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pulse_run();
        check("t1_busy", busy, 1'b1);
        check("t1_addr0", addr, 8'h0);
        wait_end(200);
        check("t1_starts", seen.size(), 3);
        check("t1_i0", seen[0], 16'h2011);
        check("t1_i1", seen[1], 16'h2822);
        check("t1_i2", seen[2], 16'h3033);
        check("t1_flags", {start, busy, done, error}, 4'b0010);
        check("t1_count", cnt, 16'd3);
        check("t1_addr", addr, 8'd2);

        rom[1] = 16'hE000;
        last = 8'd5;
        seen.delete();
        pulse_run();
        wait_end(200);
        check("t2_starts", seen.size(), 1);
        check("t2_done", {done, error, busy}, 3'b100);
        check("t2_count", cnt, 16'd1);
        check("t2_instr", instr, 16'hE000);
        check("t2_addr", addr, 8'd1);

        @(negedge clk) mode = 1;
        seen.delete();
        pulse_run();
        repeat (16) @(negedge clk);
        check("t3_err_early", error, 1'b0);
        @(negedge clk);
        check("t3_err", error, 1'b1);
        check("t3_flags", {start, busy, done}, 3'b000);
        check("t3_starts", seen.size(), 0);

        @(negedge clk) mode = 2;
        repeat (2) @(negedge clk);
        rom[1] = 16'h2822;
        last = 8'd2;
        seen.delete();
        pulse_run();
        check("t4_clear", {error, done, busy}, 3'b001);
        wait_start(50);
        repeat (16) @(negedge clk);
        check("t4_err_early", error, 1'b0);
        @(negedge clk);
        check("t4_err", {error, done, busy, start}, 4'b1000);
        check("t4_starts", seen.size(), 1);
        check("t4_instr", instr, 16'h2011);
        check("t4_count", cnt, 16'd0);
        @(negedge clk) mode = 0;
        repeat (2) @(negedge clk);
        pulse_run();
        check("t4_rerun", {error, busy}, 2'b01);
        check("t4_rerun_addr", addr, 8'h0);
        wait_end(200);
        check("t4_done", {done, error}, 2'b10);
        check("t4_count_after", cnt, 16'd3);

        seen.delete();
        pulse_run();
        wait_start(50);
        repeat (2) @(negedge clk);
        check("t5_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_flags", {start, busy, done, error}, 4'b0000);
        check("t5_rst_vals", {instr, cnt, addr}, 40'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        seen.delete();
        pulse_run();
        check("t5_count0", cnt, 16'd0);
        check("t5_addr0", addr, 8'd0);
        wait_end(200);
        check("t5_starts", seen.size(), 3);
        check("t5_first", seen[0], 16'h2011);
        check("t5_count", cnt, 16'd3);

        @(negedge clk) run2 = 1'b1;
        @(negedge clk) run2 = 1'b0;
        for (int i = 0; i < 200 && !done2; i++) @(negedge clk);
        check("t6_starts", seen2.size(), 4);
        check("t6_last", seen2[3], 16'h2404);
        check("t6_flags", {done2, busy2, error2}, 3'b100);
        check("t6_count", cnt2, 16'd4);
        check("t6_addr", addr2, 2'd3);
        check("t6_wrap", wrap2, 0);

        check("stable_instr", unstable, 0);
        check("single_start", double_start, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer on the initiator side of the controller's start/waiting handshake.
- Fetches 16-bit instructions from a synchronous instruction ROM and holds each one stable on instr for the controller to decode.
- Pulses start, waits for the controller to acknowledge (waiting low) and then complete (waiting high), then advances the PC.
- Stops on a HALT opcode, on reaching last_addr, or on a handshake timeout.

Parameters:
- ADDR_W, 8: instruction address width.
- TIMEOUT, 15: maximum consecutive cycles spent in ISSUE, ACK or EXEC before flagging an error.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, synchronous, active-low.
- run  in  1: begin execution at address 0; sampled only in IDLE, DONE or ERROR.
- last_addr  in  ADDR_W: address of the final instruction to issue.
- imem_addr  out  ADDR_W: ROM address (registered, equals PC).
- imem_rdata  in  16: ROM data, valid one cycle after imem_addr changes.
- instr  out  16: instruction presented to the controller; opcode = instr[15:13], ALU_op = instr[12:11].
- start  out  1: one-cycle request to the controller.
- waiting  in  1: controller idle/complete indication.
- busy  out  1: high whenever state is not IDLE, DONE or ERROR.
- done  out  1: program finished normally; sticky until run or reset.
- error  out  1: handshake timeout; sticky until run or reset.
- issued_count  out  16: instructions issued since the last run; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, pc/imem_addr=0, instr=0, start=0, busy=0, done=0, error=0, issued_count=0, timeout counter=0. Reset overrides every other event, including mid-handshake; start is low from the next cycle.
- All outputs are registered. start is asserted only in ISSUE.
- IDLE/DONE/ERROR, run=1 -> FETCH:
  - pc=0, imem_addr=0, clear done, error and issued_count.
  - run while busy is ignored.
- FETCH: imem_addr=pc, one cycle -> LATCH.
- LATCH: capture imem_rdata into instr.
  - If imem_rdata[15:13]==3'b111 (HALT) -> DONE; HALT is not issued and not counted.
  - Otherwise -> ISSUE.
- ISSUE:
  - If waiting==1: drive start=1 for exactly this cycle, then -> ACK.
  - If waiting==0: start=0, stay, increment the timeout counter.
- ACK: wait for waiting==0 -> EXEC. The controller drops waiting on the edge that samples start, so ACK normally lasts one cycle.
- EXEC: wait for waiting==1 -> ADVANCE.
- instr is held constant from LATCH until ADVANCE; the controller reads opcode/ALU_op over several cycles.
- ADVANCE: issued_count++ (saturating).
  - If pc==last_addr -> DONE.
  - Otherwise pc++ -> FETCH.
  - No wrap: pc==2^ADDR_W-1 always terminates in DONE, whatever last_addr is.
- Timeout:
  - The counter clears on every entry to ISSUE, ACK or EXEC and increments each cycle spent waiting there.
  - When it reaches TIMEOUT -> ERROR: error=1, start=0; pc and instr are held for debug.
- DONE: done=1, busy=0, imem_addr holds the last address fetched.
- State encodings are implementation-defined. An unreachable state -> IDLE with outputs at reset values.

Test Plan:
- ROM[0..2] = MOV-immediate instructions, last_addr=2, controller model (waiting falls the cycle after start, rises 3 cycles later), run pulse -> three single-cycle start pulses with instr = ROM[0], ROM[1], ROM[2] in order; instr stable during each handshake; then done=1, busy=0, issued_count=3, error=0.
- ROM[1]=16'hE000 (HALT), last_addr=5 -> exactly one start pulse; done=1, issued_count=1, instr=16'hE000.
- waiting held 0 at run -> start never asserted; error=1 exactly TIMEOUT cycles after entering ISSUE; done=0.
- Controller acknowledges but never raises waiting -> error=1 after TIMEOUT cycles in EXEC; start stays 0; a new run pulse restarts at imem_addr=0 with error cleared.
- rst_n low during EXEC -> the following cycle all outputs are at reset values; run afterward re-executes from address 0 and issued_count restarts at 0.
- ADDR_W=2, ROM with no HALT, last_addr=3 -> four issues, done after address 3, imem_addr never wraps to 0 before done.
